// File: rtl/video_pkg.sv
// Shared types for the video line fetcher: FSM states, pixel type, sizes.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        FETCH
    } fetch_state_t;

    typedef logic [23:0] rgb888_t;

    localparam int BYTES_PER_PIXEL = 4;

endpackage

// File: rtl/video_line_ram.sv
// Two line buffers in one simple dual-port RAM, addressed {buffer, index}.
module video_line_ram
    import video_pkg::*;
#(
    parameter int WIDTH = 800,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic    clk_i,
    input  logic    we_i,
    input  logic [IW:0] waddr_i,
    input  rgb888_t wdata_i,
    input  logic    re_i,
    input  logic [IW:0] raddr_i,
    output rgb888_t rdata_o
);

    rgb888_t mem_q [2][WIDTH];
    rgb888_t rdata_q;

    // A read colliding with a write returns the old word.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i[IW]][raddr_i[IW-1:0]];
        end
        if (we_i) begin
            mem_q[waddr_i[IW]][waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_line_fetch.sv
// Double-buffered LCD line fetcher: fills line y+1 from memory during
// blanking while line y is scanned out of the other buffer.
module video_line_fetch
    import video_pkg::*;
#(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 480
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_data_enable,
    input  logic [10:0] i_pos_x,
    input  logic [10:0] i_pos_y,
    input  logic [31:0] i_framebuffer_base,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_pixel_valid,
    output logic [23:0] o_pixel,
    output logic        o_busy,
    output logic        o_underrun
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);
    localparam logic [10:0]   LAST_LINE = 11'(HEIGHT - 1);
    localparam logic [31:0]   LINE_BYTES = 32'(WIDTH * BYTES_PER_PIXEL);

    fetch_state_t  state_q, state_d;
    logic [10:0]   y_q;
    logic [10:0]   target_q, target_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   line_addr_q, line_addr_d;
    logic          de_q, boot_q, rd_q;
    logic          underrun_q, underrun_d;
    logic          fall, rise, trigger, busy, rd_en, we;
    rgb888_t       ram_rdata;
    logic          unused_rdata_hi;

    assign fall    = de_q & ~i_data_enable;
    assign rise    = i_data_enable & ~de_q;
    assign trigger = fall | boot_q;
    assign busy    = (state_q != IDLE);
    assign rd_en   = i_data_enable && (i_pos_x < 11'(WIDTH));
    assign we      = (state_q == FETCH) && i_bus_ready;

    assign unused_rdata_hi = ^i_bus_rdata[31:24];

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        idx_d       = idx_q;
        line_addr_d = line_addr_q;
        underrun_d  = busy & (fall | rise);
        unique case (state_q)
            IDLE: ;
            START: begin
                line_addr_d = i_framebuffer_base
                            + 32'(target_q) * LINE_BYTES;
                idx_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                if (i_bus_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A new trigger always wins, aborting any fetch in flight.
        if (trigger) begin
            state_d  = START;
            target_d = (boot_q || y_q == LAST_LINE) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            idx_q       <= '0;
            line_addr_q <= '0;
            y_q         <= '0;
            de_q        <= 1'b0;
            boot_q      <= 1'b1;
            rd_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            idx_q       <= idx_d;
            line_addr_q <= line_addr_d;
            de_q        <= i_data_enable;
            boot_q      <= 1'b0;
            rd_q        <= rd_en;
            underrun_q  <= underrun_d;
            if (i_data_enable) begin
                y_q <= i_pos_y;
            end
        end
    end

    video_line_ram #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_ram (
        .clk_i   (i_clock),
        .we_i    (we),
        .waddr_i ({target_q[0], idx_q}),
        .wdata_i (i_bus_rdata[23:0]),
        .re_i    (rd_en),
        .raddr_i ({i_pos_y[0], i_pos_x[IW-1:0]}),
        .rdata_o (ram_rdata)
    );

    assign o_busy        = ~i_reset & busy;
    assign o_bus_request = ~i_reset & (state_q == FETCH);
    assign o_bus_address = o_bus_request
                         ? line_addr_q + 32'({idx_q, 2'b00}) : '0;
    assign o_pixel_valid = ~i_reset & de_q;
    assign o_pixel       = (o_pixel_valid & rd_q) ? ram_rdata : '0;
    assign o_underrun    = ~i_reset & underrun_q;

endmodule

// File: tb/tb_video_line_fetch.sv
// Bench for video_line_fetch: line-level reference model plus directed
// scenarios and randomized scan/bus traffic.
module tb_video_line_fetch;

    localparam int W = 800;
    localparam int H = 480;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de = 1'b0;
    logic [10:0] px = '0;
    logic [10:0] py = '0;
    logic [31:0] fbase = BASE;
    logic        ready = 1'b1;
    logic [31:0] rdata = '0;
    logic        req, busy, und, pv;
    logic [31:0] addr;
    logic [23:0] pix;

    always #5 clk = ~clk;

    video_line_fetch #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_data_enable      (de),
        .i_pos_x            (px),
        .i_pos_y            (py),
        .i_framebuffer_base (fbase),
        .o_bus_request      (req),
        .o_bus_address      (addr),
        .i_bus_ready        (ready),
        .i_bus_rdata        (rdata),
        .o_pixel_valid      (pv),
        .o_pixel            (pix),
        .o_busy             (busy),
        .o_underrun         (und)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bus responder ----------------
    int rmode = 0;
    int dmode = 0;
    int rcnt = 0;

    always @(posedge clk) begin
        logic [31:0] w;
        #1;
        rcnt++;
        case (rmode)
            0: ready = 1'b1;
            1: ready = (rcnt % 4 == 0);
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
        w = ((addr - fbase) >> 2) % 32'(W);
        case (dmode)
            0: rdata = {8'h00, w[23:0]};
            2: rdata = {8'hEE, w[23:0] ^ 24'h5A5A00};
            default: rdata = $urandom;
        endcase
    end

    // ---------------- reference model ----------------
    int          ph = 0;
    int          tgt = 0;
    int          idx = 0;
    int          ylast = 0;
    bit          dprev = 0;
    bit          pend = 1;
    logic [31:0] laddr = '0;
    logic [23:0] mbuf [2][W];
    bit          mk [2][W];
    bit          e_pv, e_und, e_busy, e_req, e_pixk;
    logic [23:0] e_pix;
    logic [31:0] e_addr;
    bit          started = 0;

    always @(posedge clk) begin
        bit fall, rise, trig;
        int tl;
        if (rst) begin
            ph = 0; idx = 0; dprev = 0; pend = 1; ylast = 0;
            e_und = 0; e_pv = 0; e_pix = '0; e_pixk = 1;
        end else begin
            fall = dprev && !de;
            rise = de && !dprev;
            trig = fall || pend;
            tl = (pend || ylast == H - 1) ? 0 : ylast + 1;
            e_und = (ph != 0) && (fall || rise);
            e_pv = de;
            if (de && px < W) begin
                e_pix  = mbuf[py[0]][px];
                e_pixk = mk[py[0]][px];
            end else begin
                e_pix  = '0;
                e_pixk = 1;
            end
            if (ph == 2 && ready) begin
                mbuf[tgt % 2][idx] = rdata[23:0];
                mk[tgt % 2][idx] = 1;
                idx++;
            end
            if (trig) begin
                ph = 1;
                tgt = tl;
            end else if (ph == 1) begin
                ph = 2;
                idx = 0;
                laddr = fbase + 32'(tgt * W * 4);
            end else if (ph == 2 && idx == W) begin
                ph = 0;
            end
            if (de) ylast = int'(py);
            dprev = de;
            pend = 0;
        end
        e_busy = (ph != 0);
        e_req  = (ph == 2);
        e_addr = laddr + 32'(idx * 4);
    end

    // ---------------- compare + monitor ----------------
    int          n_acc = 0;
    int          n_und = 0;
    logic [31:0] first_addr = '0;
    logic [31:0] last_addr = '0;

    always @(negedge clk) begin
        if (started) begin
            chk("busy", busy, rst ? 1'b0 : e_busy);
            chk("bus_request", req, rst ? 1'b0 : e_req);
            chk("underrun", und, rst ? 1'b0 : e_und);
            chk("pixel_valid", pv, rst ? 1'b0 : e_pv);
            if (rst || e_pixk) chk("pixel", pix, rst ? 24'h0 : e_pix);
            if (rst) chk("reset_address", addr, 0);
            else if (e_req) chk("bus_address", addr, e_addr);
            if (!rst && req && ready) begin
                if (n_acc == 0) first_addr = addr;
                last_addr = addr;
                n_acc++;
            end
            if (und) n_und++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic active(int y, int n, int x0);
        for (int i = 0; i < n; i++) begin
            de = 1'b1;
            py = 11'(y);
            px = 11'(x0 + i);
            step();
        end
        de = 1'b0;
        step();
    endtask

    task automatic wait_req(int lim);
        int i = 0;
        while (req !== 1'b1 && i < lim) begin
            step();
            i++;
        end
        chk("wait_request", req, 1);
    endtask

    task automatic wait_idle(int lim);
        int i = 0;
        while (busy !== 1'b0 && i < lim) begin
            step();
            i++;
        end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        step();
        started = 1;
        step();
        chk("reset_busy_lit", busy, 0);
        chk("reset_pixel_valid_lit", pv, 0);
        step();

        // startup fetch of line 0, ready always high
        rst = 1'b0;
        n_acc = 0; n_und = 0;
        wait_req(10);
        wait_idle(1000);
        chk("startup_accepts", n_acc, 800);
        chk("startup_first_addr", first_addr, 32'h1000_0000);
        chk("startup_last_addr", last_addr, 32'h1000_0C7C);
        chk("startup_underruns", n_und, 0);

        // line 4 -> fetch line 5 into buffer 1 with word k = k
        active(4, 16, 0);
        wait_req(10);
        chk("line5_addr", addr, 32'h1000_3E80);
        wait_idle(1000);
        for (int x = 0; x < 20; x++) begin
            de = 1'b1;
            py = 11'd5;
            px = 11'(x);
            step();
            if (x == 10) begin
                chk("line5_px10", pix, 24'h00000A);
                chk("line5_px10_valid", pv, 1);
            end
        end
        de = 1'b0;
        step();
        wait_req(10);
        chk("line6_addr", addr, 32'h1000_4B00);
        wait_idle(1000);

        // last line wraps to line 0 at the base address
        dmode = 2;
        active(479, 8, 0);
        wait_req(10);
        chk("wrap_addr", addr, BASE);
        wait_idle(1000);
        for (int x = 0; x < 6; x++) begin
            de = 1'b1;
            py = 11'd0;
            px = 11'(x);
            step();
            if (x == 3) chk("wrap_buf0_px3", pix, 24'h5A5A03);
        end
        de = 1'b0;
        step();
        wait_req(10);
        wait_idle(1000);

        // slow bus: next line starts mid-fetch
        rmode = 1;
        dmode = 1;
        active(10, 8, 0);
        wait_req(10);
        repeat (1000) step();
        n_und = 0;
        for (int x = 0; x < 8; x++) begin
            de = 1'b1;
            py = 11'd11;
            px = 11'(x);
            step();
        end
        chk("late_fetch_underruns", n_und, 1);
        de = 1'b0;
        step();
        wait_idle(8000);

        // second trigger at word 300 aborts and restarts
        rmode = 0;
        active(20, 8, 0);
        wait_req(10);
        repeat (300) step();
        n_und = 0;
        de = 1'b1;
        py = 11'd30;
        px = 11'd0;
        step();
        de = 1'b0;
        step();
        wait_req(10);
        chk("abort_restart_addr", addr, 32'h1001_8380);
        chk("abort_underruns", n_und, 2);

        // reset at word 400
        repeat (400) step();
        rst = 1'b1;
        step();
        chk("reset_drops_request", req, 0);
        step();
        rst = 1'b0;
        wait_req(10);
        chk("post_reset_addr", addr, BASE);
        wait_idle(1000);

        // randomized scan lines and bus behaviour
        rmode = 2;
        for (int l = 0; l < 14; l++) begin
            int y;
            y = (l % 5 == 4) ? H - 1 : int'($urandom_range(0, H - 1));
            if ($urandom_range(0, 2) == 0) fbase = $urandom & 32'hFFFF_FFFC;
            active(y, int'($urandom_range(1, 40)), int'($urandom_range(0, 790)));
            repeat ($urandom_range(50, 1300)) step();
        end
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_line_fetch.md
VIDEO_LINE_FETCH -- requirements
Module: video_line_fetch

Interface
REQ-001 The block SHALL be clocked on a single clock, i_clock; reset SHALL be synchronous and active-high on i_reset.
REQ-002 Parameter WIDTH, default 800, SHALL set the active pixels per line.
REQ-003 Parameter HEIGHT, default 480, SHALL set the active lines per frame.
REQ-004 Ports SHALL be exactly as follows:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous active-high reset.
- i_data_enable  in  1  active-area flag from the LCD timing generator.
- i_pos_x  in  11  scan x, valid while i_data_enable is high.
- i_pos_y  in  11  scan y, valid while i_data_enable is high.
- i_framebuffer_base  in  32  byte address of line 0, pixel 0.
- o_bus_request  out  1  memory read request.
- o_bus_address  out  32  word-aligned byte address.
- i_bus_ready  in  1  read word accepted; i_bus_rdata valid this cycle.
- i_bus_rdata  in  32  pixel word, {8'x, R, G, B}.
- o_pixel_valid  out  1  o_pixel is valid.
- o_pixel  out  24  RGB888.
- o_busy  out  1  a line fetch is in progress.
- o_underrun  out  1  single-cycle pulse on a late or aborted fetch.

Function
REQ-005 The block SHALL hold two line buffers, WIDTH x 24 bits each; line y SHALL be stored in and displayed from buffer y[0].
REQ-006 Display path: when i_data_enable is high and i_pos_x < WIDTH, buffer i_pos_y[0] SHALL be read at i_pos_x.
- o_pixel and o_pixel_valid SHALL appear exactly 1 cycle later.
- o_pixel_valid SHALL equal i_data_enable delayed 1 cycle.
- o_pixel SHALL be 0 when o_pixel_valid is low.
REQ-007 A fetch trigger SHALL be the cycle after a falling edge of i_data_enable (previous value 1, current value 0), using the registered y of the last active cycle.
REQ-008 On trigger, the target line SHALL be 0 if y == HEIGHT-1, otherwise y+1. The target is written into buffer target[0], never the buffer being displayed.
REQ-009 The FSM SHALL have three states: IDLE, START, FETCH.
- IDLE -> START on trigger.
- START (1 cycle): register line_addr = i_framebuffer_base + target*WIDTH*4 and word index 0 -> FETCH.
- FETCH -> IDLE after word WIDTH-1 is accepted.
REQ-010 In FETCH:
- o_bus_request SHALL be high.
- o_bus_address SHALL be line_addr + index*4, stable until i_bus_ready.
- Each i_bus_ready cycle SHALL write i_bus_rdata[23:0] to buffer[index] and increment index.
- Back-to-back ready cycles SHALL be accepted.
REQ-011 o_bus_request SHALL be low in IDLE and START; o_busy SHALL be high in START and FETCH.
REQ-012 A trigger arriving in START or FETCH SHALL abort the current fetch, pulse o_underrun, and restart at START with the new target.
REQ-013 If i_data_enable rises while the FSM is in START or FETCH, o_underrun SHALL pulse once; the display SHALL continue from the stale buffer contents.
REQ-014 Address arithmetic SHALL be 32-bit and wrap modulo 2^32; the target*WIDTH product SHALL be at least 21 bits wide.
REQ-015 i_framebuffer_base SHALL be sampled only in START.

Reset
REQ-016 While i_reset is high, all outputs SHALL be 0: o_bus_request, o_bus_address, o_pixel_valid, o_pixel, o_busy, o_underrun.
REQ-017 On reset, the FSM SHALL go to IDLE and the word index and edge-detect register SHALL clear; buffer contents need not clear.
REQ-018 The first cycle after reset release SHALL enter START with target line 0 (startup fetch).
REQ-019 Reset asserted mid-fetch SHALL drop o_bus_request in the next cycle; a partial line is acceptable.

Structure
REQ-020 Package video_pkg SHALL hold:
- the fetch_state_t enum (IDLE, START, FETCH);
- the rgb888_t typedef;
- localparam BYTES_PER_PIXEL = 4.
REQ-021 Line storage SHALL be one sub-module, video_line_ram: simple dual-port, 2*WIDTH x 24, one write port, one registered read port, 1-cycle read latency; the address is {buffer bit, index}.

Verification
REQ-022 Reset release, i_bus_ready constantly 1, base 0x1000_0000:
- 800 requests, addresses 0x1000_0000 to 0x1000_0C7C.
- o_busy falls after the last accept.
- No underrun.
REQ-023 Line y=5 active, buffer 1 preloaded with word k = k:
- Falling edge -> fetch of line 6 at base+6*3200.
- Reading x=10 on line 5 returns 0x00000A one cycle later, with o_pixel_valid high.
REQ-024 Falling edge at y=479 -> target line 0, address = base; buffer 0 is written.
REQ-025 i_bus_ready high 1 cycle in 4 -> 3200-cycle fetch; when the next line's enable rises mid-fetch, o_underrun pulses exactly once.
REQ-026 Second trigger at fetch word 300 -> o_underrun pulse, START re-entered, address restarts at the new line word 0.
REQ-027 i_reset asserted at word 400 -> o_bus_request low the next cycle; after release, a fetch of line 0 starts at word 0.
